// File: rtl/usbhid_report_arbiter.sv
// Round-robin arbiter that forwards one-entry-buffered HID reports from several
// hosts onto a single valid/ready report port, counting reports lost to overwrite.
module usbhid_report_arbiter #(
  parameter int C_ports       = 3,
  parameter int C_report_bits = 64,
  parameter int C_slot_bits   = 2,
  parameter int C_cnt_bits    = 8
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [C_ports*C_report_bits-1:0]   in_report,
  input  logic [C_ports-1:0]                 in_valid,
  output logic [C_report_bits-1:0]           out_data,
  output logic [C_slot_bits-1:0]             out_slot,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [C_ports-1:0]                 pending,
  output logic [C_ports*C_cnt_bits-1:0]      drop_count
);

  typedef enum logic {EMPTY, FULL} out_state_t;

  out_state_t               state;
  logic [C_report_bits-1:0] buffer [C_ports];
  logic [C_cnt_bits-1:0]    drops  [C_ports];
  logic [C_slot_bits-1:0]   last;

  logic                     load_en;
  logic                     grant_valid;
  logic [C_slot_bits-1:0]   grant_idx;
  int                       j;

  assign out_valid = (state == FULL);

  for (genvar g = 0; g < C_ports; g++) begin : g_drop
    assign drop_count[g*C_cnt_bits +: C_cnt_bits] = drops[g];
  end

  // Scan from the farthest candidate down so the nearest pending port after 'last' wins.
  always_comb begin
    load_en     = (state == EMPTY) || out_ready;
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int k = C_ports; k >= 1; k--) begin
      j = int'(last) + k;
      if (j >= C_ports) j = j - C_ports;
      if (pending[j]) begin
        grant_valid = load_en;
        grant_idx   = C_slot_bits'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= EMPTY;
      out_data <= '0;
      out_slot <= '0;
      pending  <= '0;
      last     <= C_slot_bits'(C_ports - 1);
      for (int i = 0; i < C_ports; i++) begin
        buffer[i] <= '0;
        drops[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < C_ports; i++) begin
        if (in_valid[i]) begin
          buffer[i]  <= in_report[i*C_report_bits +: C_report_bits];
          pending[i] <= 1'b1;
          // A strobe landing in the grant cycle refills the slot without losing anything.
          if (pending[i] && !(grant_valid && (int'(grant_idx) == i)) && (drops[i] != '1))
            drops[i] <= drops[i] + 1'b1;
        end else if (grant_valid && (int'(grant_idx) == i)) begin
          pending[i] <= 1'b0;
        end
      end

      if (load_en) begin
        if (grant_valid) begin
          out_data <= buffer[grant_idx];
          out_slot <= grant_idx;
          last     <= grant_idx;
          state    <= FULL;
        end else begin
          state    <= EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_usbhid_report_arbiter.sv
// Bench for usbhid_report_arbiter: directed scenarios plus random traffic against a
// queue-free behavioural model; a second instance with 2-bit counters checks saturation.
module tb_usbhid_report_arbiter;

  localparam int NP = 3;
  localparam int RB = 64;

  logic            clk;
  logic            resetn;
  logic [NP*RB-1:0] in_report;
  logic [NP-1:0]   in_valid;
  logic            out_ready;

  logic [RB-1:0]   out_data,  out_data_s;
  logic [1:0]      out_slot,  out_slot_s;
  logic            out_valid, out_valid_s;
  logic [NP-1:0]   pending,   pending_s;
  logic [NP*8-1:0] drop_count;
  logic [NP*2-1:0] drop_count_s;

  usbhid_report_arbiter dut (
    .clk(clk), .resetn(resetn), .in_report(in_report), .in_valid(in_valid),
    .out_data(out_data), .out_slot(out_slot), .out_valid(out_valid),
    .out_ready(out_ready), .pending(pending), .drop_count(drop_count)
  );

  usbhid_report_arbiter #(.C_cnt_bits(2)) dut_sat (
    .clk(clk), .resetn(resetn), .in_report(in_report), .in_valid(in_valid),
    .out_data(out_data_s), .out_slot(out_slot_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .pending(pending_s), .drop_count(drop_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state, updated once per cycle from the arbitration rules.
  bit          m_pend [NP];
  logic [63:0] m_buf  [NP];
  int          m_drop8[NP];
  int          m_drop2[NP];
  bit          m_ov;
  logic [63:0] m_od;
  int          m_os;
  int          m_last;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NP; i++) begin
      m_pend[i] = 0; m_buf[i] = '0; m_drop8[i] = 0; m_drop2[i] = 0;
    end
    m_ov = 0; m_od = '0; m_os = 0; m_last = NP - 1;
  endtask

  task automatic modelStep(input logic [NP-1:0] v, input logic [63:0] r [NP], input bit rdy);
    bit load;
    int grant;
    load  = !m_ov || rdy;
    grant = -1;
    if (load)
      for (int k = 1; k <= NP; k++)
        if (grant < 0 && m_pend[(m_last + k) % NP]) grant = (m_last + k) % NP;
    if (load) begin
      if (grant >= 0) begin
        m_od = m_buf[grant]; m_os = grant; m_ov = 1; m_last = grant;
      end else begin
        m_ov = 0;
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (v[i]) begin
        if (m_pend[i] && grant != i) begin
          if (m_drop8[i] < 255) m_drop8[i]++;
          if (m_drop2[i] < 3)   m_drop2[i]++;
        end
        m_buf[i]  = r[i];
        m_pend[i] = 1;
      end else if (grant == i) begin
        m_pend[i] = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [NP-1:0]   ep;
    logic [NP*8-1:0] ed8;
    logic [NP*2-1:0] ed2;
    for (int i = 0; i < NP; i++) begin
      ep[i]          = m_pend[i];
      ed8[i*8 +: 8]  = 8'(m_drop8[i]);
      ed2[i*2 +: 2]  = 2'(m_drop2[i]);
    end
    checkVal({tag, ".out_valid"},  64'(out_valid),    64'(m_ov));
    checkVal({tag, ".out_slot"},   64'(out_slot),     64'(m_os));
    checkVal({tag, ".out_data"},   out_data,          m_od);
    checkVal({tag, ".pending"},    64'(pending),      64'(ep));
    checkVal({tag, ".drop_count"}, 64'(drop_count),   64'(ed8));
    checkVal({tag, ".drop_sat"},   64'(drop_count_s), 64'(ed2));
  endtask

  // One clock cycle: drive inputs on the falling edge, advance the model, check at the next falling edge.
  task automatic applyStimulus(input string tag, input logic [NP-1:0] v,
                               input logic [63:0] r0, input logic [63:0] r1,
                               input logic [63:0] r2, input bit rdy);
    logic [63:0] r [NP];
    r[0] = r0; r[1] = r1; r[2] = r2;
    in_valid  = v;
    in_report = {r2, r1, r0};
    out_ready = rdy;
    modelStep(v, r, rdy);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic idle(input string tag, input bit rdy);
    applyStimulus(tag, 3'b000, '0, '0, '0, rdy);
  endtask

  task automatic doReset();
    in_valid = '0; out_ready = 1'b0;
    resetn = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset");
    resetn = 1'b1;
  endtask

  localparam logic [63:0] RA = 64'hAAAA_0000_1111_000A;
  localparam logic [63:0] RB_ = 64'hBBBB_0000_2222_000B;
  localparam logic [63:0] RC = 64'hCCCC_0000_3333_000C;

  initial begin
    logic [NP-1:0] rv;
    resetn = 1'b0; in_valid = '0; in_report = '0; out_ready = 1'b0;
    doReset();

    // Single strobe on port 1.
    for (int c = 0; c < 4; c++) idle("pre", 1'b1);
    applyStimulus("single.strobe", 3'b010, '0, 64'h1122334455667788, '0, 1'b1);
    checkVal("single.pending1", 64'(pending[1]), 64'd1);
    idle("single.beat", 1'b1);
    checkVal("single.valid", 64'(out_valid), 64'd1);
    checkVal("single.slot", 64'(out_slot), 64'd1);
    checkVal("single.data", out_data, 64'h1122334455667788);
    idle("single.after", 1'b1);
    checkVal("single.drop", 64'(out_valid), 64'd0);

    // Round-robin from a fresh pointer.
    doReset();
    applyStimulus("rr.strobe", 3'b111, RA, RB_, RC, 1'b1);
    idle("rr.b0", 1'b1);
    checkVal("rr.slot0", 64'(out_slot), 64'd0); checkVal("rr.data0", out_data, RA);
    idle("rr.b1", 1'b1);
    checkVal("rr.slot1", 64'(out_slot), 64'd1); checkVal("rr.data1", out_data, RB_);
    idle("rr.b2", 1'b1);
    checkVal("rr.slot2", 64'(out_slot), 64'd2); checkVal("rr.data2", out_data, RC);
    applyStimulus("rr.strobe02", 3'b101, RC, '0, RA, 1'b1);
    idle("rr.c0", 1'b1);
    checkVal("rr.slot0b", 64'(out_slot), 64'd0);
    idle("rr.c1", 1'b1);
    checkVal("rr.slot2b", 64'(out_slot), 64'd2);
    idle("rr.drain", 1'b1);

    // Backpressure: a beat held for 10 cycles, second port waiting.
    applyStimulus("bp.strobe", 3'b011, RB_, RC, '0, 1'b0);
    for (int c = 0; c < 10; c++) idle("bp.hold", 1'b0);
    idle("bp.release", 1'b1);
    idle("bp.next", 1'b1);
    idle("bp.drain", 1'b1);

    // Overwrite on port 2 while the output is stalled.
    applyStimulus("ow.occupy", 3'b010, '0, RA, '0, 1'b0);
    applyStimulus("ow.x", 3'b100, '0, '0, 64'h1, 1'b0);
    applyStimulus("ow.y", 3'b100, '0, '0, 64'h2, 1'b0);
    applyStimulus("ow.z", 3'b100, '0, '0, 64'h3, 1'b0);
    checkVal("ow.drop2", 64'(drop_count[16 +: 8]), 64'd2);
    for (int c = 0; c < 4; c++) idle("ow.release", 1'b1);

    // Grant and capture on the same port in the same cycle.
    applyStimulus("gc.a", 3'b001, RA, '0, '0, 1'b1);
    applyStimulus("gc.b", 3'b001, RB_, '0, '0, 1'b1);
    checkVal("gc.dataA", out_data, RA);
    idle("gc.fwdB", 1'b1);
    checkVal("gc.dataB", out_data, RB_);
    idle("gc.drain", 1'b1);

    // Saturation on the 2-bit instance, then reset in the middle of a held beat.
    doReset();
    applyStimulus("sat.occupy", 3'b010, '0, RC, '0, 1'b0);
    for (int c = 0; c < 6; c++) applyStimulus("sat.ow", 3'b001, 64'(c), '0, '0, 1'b0);
    checkVal("sat.drop2bit", 64'(drop_count_s[1:0]), 64'd3);
    checkVal("sat.drop8bit", 64'(drop_count[7:0]),   64'd5);
    #2 resetn = 1'b0;
    #1;
    checkVal("rst.valid", 64'(out_valid), 64'd0);
    checkVal("rst.pending", 64'(pending), 64'd0);
    modelReset();
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus("rst.strobe", 3'b111, RA, RB_, RC, 1'b1);
    idle("rst.first", 1'b1);
    checkVal("rst.firstslot", 64'(out_slot), 64'd0);
    for (int c = 0; c < 3; c++) idle("rst.drain", 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rv = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) rv = '0;
      applyStimulus("rand", rv, {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, ($urandom_range(0, 9) < 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usbhid_report_arbiter.md
Name: usbhid_report_arbiter

Overview:
- Shares one report-write port between up to C_ports usbh_host_hid instances that all run on the common USB clock.
- Each host's hid_valid pulse captures its report into a per-port one-entry pending buffer.
- A round-robin scheduler forwards buffered reports, tagged with the source slot, through a valid/ready output to the single consumer (display register writer or any other report sink).
- Reports that are overwritten before being forwarded are counted per port.

Parameters:
- C_ports, 3, number of HID host requesters (1..8).
- C_report_bits, 64, report width per port.
- C_slot_bits, 2, width of the slot index; must satisfy 2**C_slot_bits >= C_ports.
- C_cnt_bits, 8, width of each per-port drop counter.

Ports:
- clk  input  1  USB clock (6 or 48 MHz); all logic on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_report  input  C_ports*C_report_bits  port i occupies bits [i*C_report_bits +: C_report_bits].
- in_valid  input  C_ports  one-cycle capture strobe per port (hid_valid).
- out_data  output  C_report_bits  forwarded report.
- out_slot  output  C_slot_bits  source port of out_data.
- out_valid  output  1  out_data/out_slot valid.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- pending  output  C_ports  buffer-full flag per port.
- drop_count  output  C_ports*C_cnt_bits  saturating overwrite counter per port, same packing as in_report.

Behaviour:
- Reset (async assert, sync release):
  - pending = 0, out_valid = 0, out_data = 0, out_slot = 0, all drop_count = 0.
  - Round-robin pointer last = C_ports-1, so port 0 has first priority.
- Capture, per port i, each cycle:
  - in_valid[i] & !pending[i]: buffer[i] <= report, pending[i] <= 1.
  - in_valid[i] & pending[i] & port i granted this cycle: the granted (old) data goes to the output register, the new report is written to buffer[i], pending[i] stays 1, no drop counted.
  - in_valid[i] & pending[i] & not granted: buffer[i] <= newest report (latest wins), drop_count[i] += 1, saturating at 2**C_cnt_bits-1.
  - Otherwise, a grant clears pending[i].
- Output register: two states, EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - load_en = !out_valid | out_ready.
  - When load_en and any pending is set: grant the first pending port searching last+1, last+2, … modulo C_ports. Then out_data <= buffer[g], out_slot <= g, out_valid <= 1, last <= g.
  - When load_en and nothing is pending: out_valid <= 0. out_data and out_slot hold their previous values.
  - While out_valid & !out_ready, out_data and out_slot are stable and no grant occurs.
- Grant uses registered pending and buffer values. A report strobed in cycle N is therefore pending in N+1 and presented at out_valid in N+2 at the earliest, with an idle output and no competing ports.
- Throughput: with out_ready held high, one report per cycle is forwarded back-to-back with no bubble.
- Fairness: with all ports continuously pending and out_ready = 1, grant order is 0,1,2,0,1,2,…; no port waits more than C_ports grants.
- in_valid on a port with index >= C_ports does not exist. Bits of out_slot above the port range are always 0.
- Reset mid-transfer: out_valid drops immediately (asynchronously); buffered reports are discarded.

Test Plan:
- Single strobe: reset, in_valid[1] for 1 cycle in cycle 5 with report 0x1122334455667788, out_ready = 1 -> pending[1] = 1 in cycle 6. out_valid = 1, out_slot = 1, out_data = 0x1122334455667788 in cycle 7. out_valid = 0 in cycle 8.
- Round-robin: strobe all 3 ports in the same cycle with reports A, B, C, out_ready = 1 -> three consecutive output beats with slots 0, 1, 2 and data A, B, C. Then strike ports 0 and 2 together -> slots 0, then 2.
- Backpressure: out_ready = 0 while one beat is presented for 10 cycles -> out_data and out_slot are unchanged every cycle. Raise out_ready -> the beat is accepted once and the next pending slot appears the following cycle.
- Overwrite: out_ready = 0, strobe port 2 with X then Y then Z -> drop_count[2] = 2. After release, out_data = Z, slot 2.
- Simultaneous grant and capture: port 0 pending with A, output accepting, in_valid[0] with B in the grant cycle -> A is forwarded, B stays pending, drop_count[0] = 0, then B is forwarded.
- Saturation and reset: C_cnt_bits = 2, five overwrites -> drop_count = 3. Assert resetn low mid-beat -> out_valid = 0 and pending = 0 immediately. After release, the first grant is to port 0.
